// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch
// requester and the data (LDR/STR) requester of the ARM32 core. Each access
// is serialised as IDLE -> ACCESS (LATENCY cycles) -> RESP. The grant is a
// combinational pulse in the IDLE cycle where the request is seen. The
// completion (rvalid) pulse follows LATENCY+1 cycles later.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate using a
//                        1-bit last-granted pointer (reset value "fetch", so
//                        data wins the first collision). When undefined,
//                        data always has priority over fetch.
//
// Parameters:
//   LATENCY - memory cycles from mem_en to valid mem_rdata (1..15)
//   AW, DW  - address / data width
//
// Ports:
//   clk, reset                       clock (rising edge), async active-low reset
//   if_req/if_addr                   fetch request and byte address
//   if_gnt/if_rvalid/if_rdata        fetch grant, completion pulse, read data
//   d_req/d_we/d_addr/d_wdata        data request, store flag, address, data
//   d_gnt/d_rvalid/d_rdata           data grant, completion pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata memory access strobe and command
//   mem_rdata                        memory read data
//   busy                             high whenever an access is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LATENCY);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [3:0]    cnt_r;
    logic          win_data_r;     // 1 = data requester owns the access
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] d_rdata_r;
    logic          grant_data_s;
    logic          grant_fetch_s;
    logic          take_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic          last_data_r;    // 1 = last grant went to data, 0 = fetch

    // Last-granted pointer, updated on every grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_data_r <= 1'b0;
        end else if (take_s) begin
            last_data_r <= grant_data_s;
        end else begin
            last_data_r <= last_data_r;
        end
    end
`endif

    // Arbitration: pick the winner among the currently presented requests
    always_comb begin
        grant_data_s  = 1'b0;
        grant_fetch_s = 1'b0;
        if (d_req && if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // The requester that was not granted last wins the collision
            if (last_data_r) begin
                grant_fetch_s = 1'b1;
            end else begin
                grant_data_s  = 1'b1;
            end
`else
            grant_data_s  = 1'b1;
`endif
        end else if (d_req) begin
            grant_data_s  = 1'b1;
        end else if (if_req) begin
            grant_fetch_s = 1'b1;
        end else begin
            grant_data_s  = 1'b0;
            grant_fetch_s = 1'b0;
        end
    end

    assign take_s = (state_r == ST_IDLE) && (d_req || if_req);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (d_req || if_req) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch the winning command, run the latency counter, capture load data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r      <= 4'd0;
            win_data_r <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {AW{1'b0}};
            wdata_r    <= {DW{1'b0}};
            if_rdata_r <= {DW{1'b0}};
            d_rdata_r  <= {DW{1'b0}};
        end else if (take_s) begin
            cnt_r      <= LAT_C;
            win_data_r <= grant_data_s;
            we_r       <= grant_data_s & d_we;
            addr_r     <= grant_data_s ? d_addr : if_addr;
            wdata_r    <= grant_data_s ? d_wdata : {DW{1'b0}};
        end else if (state_r == ST_ACCESS) begin
            cnt_r <= cnt_r - 4'd1;
            // Last ACCESS cycle: memory data is valid now; stores leave rdata alone
            if ((cnt_r == 4'd1) && !we_r) begin
                if (win_data_r) begin
                    d_rdata_r  <= mem_rdata;
                end else begin
                    if_rdata_r <= mem_rdata;
                end
            end
        end
    end

    // Output decode; grants are additionally gated by reset so that every
    // output is low while reset is held, even with requests pending
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if_gnt = reset & grant_fetch_s;
                d_gnt  = reset & grant_data_s;
            end
            ST_ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_r;
                mem_addr  = addr_r;
                mem_wdata = wdata_r;
            end
            ST_RESP: begin
                if_rvalid = ~win_data_r;
                d_rvalid  = win_data_r;
            end
            default: begin
                if_gnt = 1'b0;
                d_gnt  = 1'b0;
            end
        endcase
        busy = (state_r != ST_IDLE);
    end

    assign if_rdata = if_rdata_r;
    assign d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed and randomized stimulus for mem_port_arbiter (LATENCY=3). A small
// behavioural memory answers mem_en with data that is only valid in the
// LATENCY-th enabled cycle. Expected grants, timing and read data come from a
// transaction-level model: winner by the priority rule, fixed gnt->rvalid
// distance, and a reference copy of the memory contents.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.LATENCY(LAT), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural memory ----------------
    function automatic logic [31:0] init_val(input int idx);
        return (32'(idx) * 32'h9E37_79B1) ^ 32'hE081_3002;
    endfunction

    logic [31:0] mem_arr [0:255];
    bit   [255:0] written;
    int          en_cnt;

    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_we) begin
                mem_arr[mem_addr[9:2]] <= mem_wdata;
                written[mem_addr[9:2]] <= 1'b1;
            end
        end else begin
            en_cnt <= 0;
        end
    end

    assign mem_rdata = (mem_en && (en_cnt == LAT - 1)) ?
                       (written[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]]
                                               : init_val(int'(mem_addr[9:2])))
                       : 32'hDEAD_BEEF;

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    bit          last_data;   // round-robin pointer model (1 = data last)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdata();
        chk("if_rdata_hold", if_rdata, exp_if_rdata);
        chk("d_rdata_hold", d_rdata, exp_d_rdata);
    endtask

    // One cycle with no requests: nothing may happen
    task automatic idle_cycle();
        @(negedge clk);
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        #2;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("idle_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk_rdata();
    endtask

    // One complete transaction starting in IDLE; inputs stay presented until
    // the RESP cycle so a losing requester keeps waiting
    task automatic txn(input bit fr, input bit dr, input bit dwe,
                       input logic [31:0] fa, input logic [31:0] da,
                       input logic [31:0] dwd);
        bit          win_d;
        logic [31:0] ea;
        logic [31:0] ewd;
        bit          ewe;
        if (!fr && !dr) begin
            idle_cycle();
            return;
        end
        @(negedge clk);
        if_req  = fr;
        if_addr = fa;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        #2;
`ifdef ARB_ROUND_ROBIN_EN
        win_d = dr && (!fr || !last_data);
        last_data = win_d;
`else
        win_d = dr;
`endif
        ea  = win_d ? da : fa;
        ewe = win_d && dwe;
        ewd = win_d ? dwd : 32'd0;
        chk("gnt_d", 32'(d_gnt), 32'(win_d));
        chk("gnt_if", 32'(if_gnt), 32'(!win_d));
        chk("gnt_busy", 32'(busy), 32'd0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            #2;
            chk("acc_mem_en", 32'(mem_en), 32'd1);
            chk("acc_addr", mem_addr, ea);
            chk("acc_we", 32'(mem_we), 32'(ewe));
            if (ewe) chk("acc_wdata", mem_wdata, ewd);
            chk("acc_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
            chk("acc_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            chk("acc_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        #2;
        if (win_d && dwe) ref_mem[da[9:2]] = dwd;
        else if (win_d) exp_d_rdata = ref_mem[da[9:2]];
        else exp_if_rdata = ref_mem[fa[9:2]];
        chk("resp_rvalid", {30'd0, if_rvalid, d_rvalid}, win_d ? 32'd1 : 32'd2);
        chk("resp_mem_en", 32'(mem_en), 32'd0);
        chk("resp_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("resp_busy", 32'(busy), 32'd1);
        chk_rdata();
    endtask

    function automatic logic [31:0] rnd_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        exp_if_rdata = 32'd0;
        exp_d_rdata  = 32'd0;
        last_data    = 1'b0;
        reset   = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk_rdata();
        @(negedge clk);
        reset = 1'b1;
        idle_cycle();

        // Fetch read at 0x8
        txn(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0);
        idle_cycle();

        // Store 0x5 to 0x40, then read it back through both ports
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h5);
        idle_cycle();
        txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0);
        idle_cycle();

        // Three back-to-back collisions
        for (int i = 0; i < 3; i++)
            txn(1'b1, 1'b1, 1'b0, rnd_addr(), rnd_addr(), 32'd0);
        idle_cycle();

        // Asynchronous reset in the middle of an access, request held high
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h10;
        #2;
        chk("pre_rst_gnt", 32'(if_gnt), 32'd1);
        @(negedge clk);
        #2;
        chk("pre_rst_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b0;
        #1;
        exp_if_rdata = 32'd0;
        exp_d_rdata  = 32'd0;
        last_data    = 1'b0;
        chk("arst_mem_en", 32'(mem_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("arst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk_rdata();
        @(negedge clk);
        #2;
        chk("arst_hold_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        if_req = 1'b0;
        reset  = 1'b1;
        repeat (4) idle_cycle();
        txn(1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0);

        // Continuous fetch stream 0x0, 0x4, 0x8
        txn(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        txn(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0);
        txn(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0);

        // Randomized mix of fetch, load, store, collisions and idle
        for (int i = 0; i < 60; i++) begin
            int pat;
            pat = int'($urandom_range(0, 3));
            txn(pat[0], pat[1], 1'($urandom_range(0, 1)),
                rnd_addr(), rnd_addr(), $urandom);
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
